// File: rtl/muldiv_seq_if.sv
// Execute-stage interface to the HI/LO multiply/divide sequencer.
// The core side is the master; the sequencer is the slave.
interface muldiv_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             startE;
    logic [1:0]       opE;
    logic [WIDTH-1:0] srcaE;
    logic [WIDTH-1:0] srcbE;
    logic             hienE;
    logic             loenE;
    logic [WIDTH-1:0] wdataE;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output startE, opE, srcaE, srcbE, hienE, loenE, wdataE,
        input  busy, done, hi, lo
    );

    modport slave (
        input  startE, opE, srcaE, srcbE, hienE, loenE, wdataE,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative one-bit-per-cycle mult/multu/div/divu sequencer owning HI/LO.
// Operands are held as magnitudes; signs are re-applied in the FIX state.
module muldiv_seq #(
    parameter int unsigned WIDTH = 32
) (
    input logic          clk,
    input logic          reset,
    muldiv_seq_if.slave  bus
);
    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] a_raw_q, a_raw_d;
    logic             is_div_q, is_div_d;
    logic             is_sgn_q, is_sgn_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic             divz_q, divz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic             start_sgn;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_cand;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem;
    logic [W2-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign start_sgn = ~bus.opE[0];
    assign abs_a     = (start_sgn && bus.srcaE[WIDTH-1]) ? -bus.srcaE : bus.srcaE;
    assign abs_b     = (start_sgn && bus.srcbE[WIDTH-1]) ? -bus.srcbE : bus.srcbE;

    // Multiply: add B into the upper half when the LSB is set, then shift right.
    assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);

    // Divide: remainder in the upper half, dividend shifting out of the lower half.
    assign div_cand = acc_q[W2-1:WIDTH-1];
    assign div_diff = div_cand - {1'b0, b_q};
    assign div_ge   = (div_cand >= {1'b0, b_q});
    assign div_rem  = div_ge ? div_diff[WIDTH-1:0] : div_cand[WIDTH-1:0];

    assign prod_fix = (is_sgn_q && (sign_a_q ^ sign_b_q)) ? -acc_q : acc_q;
    assign quo_fix  = (is_sgn_q && (sign_a_q ^ sign_b_q)) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = (is_sgn_q && sign_a_q) ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        b_d      = b_q;
        a_raw_d  = a_raw_q;
        is_div_d = is_div_q;
        is_sgn_d = is_sgn_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        divz_d   = divz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.hienE) hi_d = bus.wdataE;
                if (bus.loenE) lo_d = bus.wdataE;
                if (bus.startE) begin
                    state_d  = RUN;
                    count_d  = CW'(WIDTH - 1);
                    acc_d    = {{WIDTH{1'b0}}, abs_a};
                    b_d      = abs_b;
                    a_raw_d  = bus.srcaE;
                    is_div_d = bus.opE[1];
                    is_sgn_d = start_sgn;
                    sign_a_d = bus.srcaE[WIDTH-1];
                    sign_b_d = bus.srcbE[WIDTH-1];
                    divz_d   = bus.opE[1] && (bus.srcbE == '0);
                end
            end
            RUN: begin
                if (is_div_q) acc_d = {div_rem, acc_q[WIDTH-2:0], div_ge};
                else          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                if (count_q == '0) state_d = FIX;
                else               count_d = count_q - 1'b1;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    hi_d = prod_fix[W2-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (divz_q) begin
                    hi_d = a_raw_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            a_raw_q  <= '0;
            is_div_q <= 1'b0;
            is_sgn_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            divz_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            a_raw_q  <= a_raw_d;
            is_div_q <= is_div_d;
            is_sgn_q <= is_sgn_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            divz_q   <= divz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: latency, signed/unsigned results, edge cases,
// mthi/mtlo handling, ignored restart and mid-operation reset.
module tb_muldiv_seq;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    muldiv_seq_if #(.WIDTH(32)) bus ();
    muldiv_seq #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic idle_inputs();
        bus.startE = 1'b0;
        bus.opE    = 2'b00;
        bus.srcaE  = '0;
        bus.srcbE  = '0;
        bus.hienE  = 1'b0;
        bus.loenE  = 1'b0;
        bus.wdataE = '0;
    endtask

    // Full operation: start at edge 0, busy cycles 1..33, result + done in cycle 34.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input string nm);
        int nbusy;
        @(negedge clk);
        bus.startE = 1'b1; bus.opE = op; bus.srcaE = a; bus.srcbE = b;
        @(negedge clk);
        bus.startE = 1'b0; bus.srcaE = ~a; bus.srcbE = ~b;
        nbusy = 0;
        for (int c = 1; c <= 33; c++) begin
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) nbusy++;
            if (c < 33) @(negedge clk);
        end
        total++;
        if (nbusy != 0) begin
            bad++;
            $display("FAIL %s busy_window: %0d bad cycles of 33, required 0", nm, nbusy);
        end
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b1) begin
            bad++;
            $display("FAIL %s cycle34_flags: busy=%b done=%b, required busy=0 done=1", nm, bus.busy, bus.done);
        end
        total++;
        if (bus.hi !== eh || bus.lo !== el) begin
            bad++;
            $display("FAIL %s result: hi=%h lo=%h, required hi=%h lo=%h", nm, bus.hi, bus.lo, eh, el);
        end
        @(negedge clk);
        total++;
        if (bus.done !== 1'b0 || bus.hi !== eh || bus.lo !== el) begin
            bad++;
            $display("FAIL %s cycle35_hold: done=%b hi=%h lo=%h, required done=0 hi=%h lo=%h",
                     nm, bus.done, bus.hi, bus.lo, eh, el);
        end
        bus.srcaE = '0; bus.srcbE = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0",
                     bus.busy, bus.done, bus.hi, bus.lo);
        end
        reset = 1'b0;
    endtask

    task automatic test_mult();
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg3x5");
        run_op(2'b00, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 32'h0000_0000, 32'h0000_002A, "mult_neg7xneg6");
    endtask

    task automatic test_div();
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7by2");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_min_by_neg1");
        run_op(2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, "divu_100by7");
        run_op(2'b10, 32'h0000_0011, 32'hFFFF_FFFB, 32'h0000_0002, 32'hFFFF_FFFD, "div_17byneg5");
    endtask

    task automatic test_divzero();
        run_op(2'b11, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, "divu_by_zero");
        run_op(2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_neg_by_zero");
    endtask

    // A second start while busy must neither restart nor queue an operation.
    task automatic test_ignored_start();
        int ndone;
        int done_cyc;
        @(negedge clk);
        bus.startE = 1'b1; bus.opE = 2'b00; bus.srcaE = 32'h0001_0000; bus.srcbE = 32'h0001_0000;
        @(negedge clk);
        bus.startE = 1'b0;
        ndone = 0; done_cyc = 0;
        for (int c = 1; c <= 80; c++) begin
            if (c == 10) begin
                bus.startE = 1'b1; bus.opE = 2'b11; bus.srcaE = 32'd100; bus.srcbE = 32'd7;
            end else begin
                bus.startE = 1'b0;
            end
            if (bus.done === 1'b1) begin
                ndone++;
                done_cyc = c;
            end
            @(negedge clk);
        end
        total++;
        if (ndone != 1 || done_cyc != 34) begin
            bad++;
            $display("FAIL ignored_start_done: %0d pulses last at cycle %0d, required 1 at cycle 34", ndone, done_cyc);
        end
        total++;
        if (bus.hi !== 32'h0000_0001 || bus.lo !== 32'h0000_0000 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL ignored_start_result: busy=%b hi=%h lo=%h, required busy=0 hi=00000001 lo=00000000",
                     bus.busy, bus.hi, bus.lo);
        end
    endtask

    task automatic test_mt();
        @(negedge clk);
        bus.hienE = 1'b1; bus.wdataE = 32'h0000_1234;
        @(negedge clk);
        bus.hienE = 1'b0;
        total++;
        if (bus.hi !== 32'h0000_1234 || bus.lo !== 32'h0000_0000) begin
            bad++;
            $display("FAIL mthi_idle: hi=%h lo=%h, required hi=00001234 lo=00000000", bus.hi, bus.lo);
        end
        bus.hienE = 1'b1; bus.loenE = 1'b1; bus.wdataE = 32'hCAFE_F00D;
        @(negedge clk);
        bus.hienE = 1'b0; bus.loenE = 1'b0;
        total++;
        if (bus.hi !== 32'hCAFE_F00D || bus.lo !== 32'hCAFE_F00D) begin
            bad++;
            $display("FAIL mthi_mtlo_both: hi=%h lo=%h, required cafef00d cafef00d", bus.hi, bus.lo);
        end
        // Start with a simultaneous mthi, then an mtlo attempt while busy.
        bus.startE = 1'b1; bus.opE = 2'b01; bus.srcaE = 32'd6; bus.srcbE = 32'd7;
        bus.hienE = 1'b1; bus.wdataE = 32'h0000_5555;
        @(negedge clk);
        bus.startE = 1'b0; bus.hienE = 1'b0;
        total++;
        if (bus.hi !== 32'h0000_5555 || bus.lo !== 32'hCAFE_F00D || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL mthi_with_start: busy=%b hi=%h lo=%h, required 1 00005555 cafef00d",
                     bus.busy, bus.hi, bus.lo);
        end
        repeat (4) @(negedge clk);
        bus.loenE = 1'b1; bus.wdataE = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.loenE = 1'b0;
        total++;
        if (bus.lo !== 32'hCAFE_F00D || bus.hi !== 32'h0000_5555) begin
            bad++;
            $display("FAIL mtlo_busy_dropped: hi=%h lo=%h, required 00005555 cafef00d", bus.hi, bus.lo);
        end
        repeat (28) @(negedge clk);
        total++;
        if (bus.done !== 1'b1 || bus.hi !== 32'h0 || bus.lo !== 32'd42) begin
            bad++;
            $display("FAIL mt_then_result: done=%b hi=%h lo=%h, required 1 00000000 0000002a",
                     bus.done, bus.hi, bus.lo);
        end
    endtask

    task automatic test_reset_midop();
        int ndone;
        @(negedge clk);
        bus.startE = 1'b1; bus.opE = 2'b11; bus.srcaE = 32'd1000; bus.srcbE = 32'd3;
        @(negedge clk);
        bus.startE = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            bad++;
            $display("FAIL reset_midop: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0",
                     bus.busy, bus.done, bus.hi, bus.lo);
        end
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
            @(negedge clk);
        end
        total++;
        if (ndone != 0 || bus.lo !== 32'h0) begin
            bad++;
            $display("FAIL reset_abort_quiet: %0d active cycles lo=%h, required 0 and 00000000", ndone, bus.lo);
        end
        run_op(2'b01, 32'd6, 32'd7, 32'h0, 32'd42, "multu_after_reset");
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_divzero();
        test_ignored_start();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        test_mt();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Iterative multiply/divide sequencer that owns the HI/LO register pair for the pipelined MIPS core. It is launched from the Execute stage by mult/multu/div/divu and runs one bit per cycle. It asserts busy so the hazard unit can stall any mfhi/mflo or new mult/div until the result is written. It also services mthi/mtlo writes, which use the same write enables the decoder already produces for HI and LO.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
startE  in  1  launch a mult/div operation (sampled on the rising edge)
opE  in  2  00 mult (signed), 01 multu, 10 div (signed), 11 divu
srcaE  in  WIDTH  operand A (multiplicand / dividend)
srcbE  in  WIDTH  operand B (multiplier / divisor)
hienE  in  1  mthi write enable
loenE  in  1  mtlo write enable
wdataE  in  WIDTH  mthi/mtlo write data
busy  out  1  sequencer not idle; hazard unit stalls on this
done  out  1  one-cycle pulse, HI/LO just updated by mult/div
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- One clock; reset is synchronous and active-high. Reset gives state=IDLE, hi=0, lo=0, busy=0, done=0, count=0.
- Reset mid-operation aborts the operation immediately, with no HI/LO update.
- States:
  - IDLE -> RUN when startE=1 at the edge.
  - RUN runs for exactly WIDTH cycles (count WIDTH-1 down to 0), then goes to FIX.
  - FIX -> IDLE unconditionally.
- busy = (state != IDLE), decoded from state register bits.
- Latency with startE sampled at edge 0:
  - busy is high in cycles 1..WIDTH+1 (33 cycles for WIDTH=32).
  - hi/lo update at the FIX->IDLE edge and are visible in cycle WIDTH+2.
  - done is a registered pulse, high for that cycle only.
- At start: latch the operation kind, |A| and |B|, and the sign flags.
  - Signed ops take two's-complement magnitudes; unsigned ops use the operands raw.
  - Operands are not re-sampled after start.
- Multiply: shift-add over a 2*WIDTH accumulator. In FIX, negate the 64-bit product if signed and the signs differ. Result: hi = upper half, lo = lower half.
- Divide: restoring, one quotient bit per cycle.
  - In FIX, the quotient is negated if signed and the signs differ.
  - The remainder takes the dividend's sign.
  - Result: lo = quotient, hi = remainder.
  - Signed MIN / -1 gives lo = 0x80000000, hi = 0 (wrap, no trap).
- Divide by zero, detected at start: lo = all ones, hi = srcaE, no sign fix-up. It still takes the full WIDTH+1 busy cycles.
- startE while busy is ignored; no restart, no queuing. The hazard unit must prevent it.
- mthi/mtlo (hienE/loenE):
  - In IDLE, hi/lo <= wdataE at the edge. Both enables may be set together.
  - While busy they are dropped.
  - startE together with hienE/loenE in IDLE: the write is applied, and the later FIX result overwrites it.
- In FIX->IDLE, the mult/div result always wins; no mt* write can coincide, since it would be dropped as busy.
- hi/lo hold their value in every other cycle. done=0 except for the single pulse.
- No combinational path from any input to busy or done.

Test Plan:
1. Reset, then multu with A=0xFFFFFFFF, B=0xFFFFFFFF -> busy high cycles 1..33; cycle 34 gives hi=0xFFFFFFFE, lo=0x00000001, done=1 for one cycle.
2. mult with A=-3, B=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. div with A=-7, B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. div with A=0x80000000, B=-1 -> lo=0x80000000, hi=0.
3. divu with A=7, B=0 -> lo=0xFFFFFFFF, hi=7 after the full 33-cycle busy window. divu with A=100, B=7 -> lo=14, hi=2.
4. Start a mult, pulse startE with a div opcode and different operands at cycle 10 -> ignored; the original product is written at cycle 34; done pulses once.
5. In IDLE, hienE=1 with wdataE=0x1234 -> hi=0x1234 next cycle, lo unchanged. During busy, loenE=1 -> lo unchanged until the result is written.
6. Assert reset at cycle 15 of a divide -> next cycle state=IDLE, busy=0, hi=lo=0, done=0; a fresh multu 6*7 then gives lo=42, hi=0.
